// File: rtl/cpu_ctrl_pkg.sv
// Shared types, constants and microcode for the 8-bit CPU instruction sequencer.
// Holds the opcode map, control-word bit positions, FSM encoding and decode helpers.
package cpu_ctrl_pkg;

    localparam int PHASES = 8;
    localparam int OPW    = 4;
    localparam int CW     = 16;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_LDA = 4'h1;
    localparam logic [OPW-1:0] OP_ADD = 4'h2;
    localparam logic [OPW-1:0] OP_SUB = 4'h3;
    localparam logic [OPW-1:0] OP_STA = 4'h4;
    localparam logic [OPW-1:0] OP_LDI = 4'h5;
    localparam logic [OPW-1:0] OP_JMP = 4'h6;
    localparam logic [OPW-1:0] OP_OUT = 4'hE;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    localparam int C_PC_OUT  = 0;
    localparam int C_PC_INC  = 1;
    localparam int C_MAR_LD  = 2;
    localparam int C_MEM_RD  = 3;
    localparam int C_MEM_WR  = 4;
    localparam int C_IR_LD   = 5;
    localparam int C_IR_OUT  = 6;
    localparam int C_A_LD    = 7;
    localparam int C_A_OUT   = 8;
    localparam int C_B_LD    = 9;
    localparam int C_ALU_OUT = 10;
    localparam int C_ALU_SUB = 11;
    localparam int C_OUT_LD  = 12;
    localparam int C_PC_LD   = 13;
    localparam int C_FLAG_LD = 14;
    localparam int C_HLT     = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Number of execute phases after the 3-phase fetch; undefined opcodes behave as NOP.
    function automatic logic [2:0] exec_len(input logic [OPW-1:0] op);
        case (op)
            OP_LDA:                         exec_len = 3'd2;
            OP_ADD, OP_SUB:                 exec_len = 3'd3;
            OP_STA:                         exec_len = 3'd2;
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: exec_len = 3'd1;
            default:                        exec_len = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [PHASES-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < PHASES; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] ucode(input logic [OPW-1:0] op, input logic [2:0] ph);
        logic [CW-1:0] cw;
        cw = '0;
        case (ph)
            3'd0: begin cw[C_PC_OUT] = 1'b1; cw[C_MAR_LD] = 1'b1; end
            3'd1: begin cw[C_MEM_RD] = 1'b1; cw[C_IR_LD]  = 1'b1; end
            3'd2: begin cw[C_PC_INC] = 1'b1; end
            3'd3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin cw[C_IR_OUT] = 1'b1; cw[C_MAR_LD] = 1'b1; end
                    OP_LDI:  begin cw[C_IR_OUT] = 1'b1; cw[C_A_LD]   = 1'b1; end
                    OP_JMP:  begin cw[C_IR_OUT] = 1'b1; cw[C_PC_LD]  = 1'b1; end
                    OP_OUT:  begin cw[C_A_OUT]  = 1'b1; cw[C_OUT_LD] = 1'b1; end
                    OP_HLT:  begin cw[C_HLT]    = 1'b1; end
                    default: cw = '0;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_LDA:         begin cw[C_MEM_RD] = 1'b1; cw[C_A_LD]   = 1'b1; end
                    OP_ADD, OP_SUB: begin cw[C_MEM_RD] = 1'b1; cw[C_B_LD]   = 1'b1; end
                    OP_STA:         begin cw[C_A_OUT]  = 1'b1; cw[C_MEM_WR] = 1'b1; end
                    default:        cw = '0;
                endcase
            end
            3'd5: begin
                case (op)
                    OP_ADD: begin
                        cw[C_ALU_OUT] = 1'b1; cw[C_A_LD] = 1'b1; cw[C_FLAG_LD] = 1'b1;
                    end
                    OP_SUB: begin
                        cw[C_ALU_OUT] = 1'b1; cw[C_A_LD] = 1'b1; cw[C_FLAG_LD] = 1'b1;
                        cw[C_ALU_SUB] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/cpu_ctrl_seq_phase_ring.sv
// One-hot timing-phase ring: rotates left when enabled, clr returns it to T0.
// clr has priority over en so the sequencer can restart fetch from any phase.
module phase_ring #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] phase
);

    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] phase_d;

    // Next ring value.
    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = WIDTH'(1);
        end else if (en) begin
            phase_d = {phase_q[WIDTH-2:0], phase_q[WIDTH-1]};
        end else begin
            phase_d = phase_q;
        end
    end

    // Ring register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= WIDTH'(1);
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer: fetch/execute FSM, opcode register and control-word decode.
// ctrl_o is decoded from registered state, phase and opcode; it is zero in IDLE and HALT.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [7:0]        ir_i,
    output logic [PHASES-1:0] phase_o,
    output logic [CW-1:0]     ctrl_o,
    output logic              busy_o,
    output logic              instr_done_o,
    output logic              halt_o
);

    state_e            state_q, state_d;
    logic [OPW-1:0]    opcode_q, opcode_d;
    logic [PHASES-1:0] phase_s;
    logic [2:0]        phase_idx_s;
    logic              busy_s;
    logic              last_s;
    logic              ring_clr_s;
    logic              unused_ir_s;

    assign unused_ir_s = ^ir_i[3:0];
    assign phase_idx_s = onehot_idx(phase_s);
    assign busy_s      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign ring_clr_s  = !busy_s || last_s;

    phase_ring #(.WIDTH(PHASES)) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clr   (ring_clr_s),
        .en    (busy_s),
        .phase (phase_s)
    );

    // Last phase of the current instruction; a zero-length opcode finishes at T2,
    // which must look at ir_i because the opcode register only loads at the end of T2.
    always_comb begin
        last_s = 1'b0;
        case (state_q)
            ST_FETCH: last_s = phase_s[2] && (exec_len(ir_i[7:4]) == 3'd0);
            ST_EXEC:  last_s = (phase_idx_s == (3'd2 + exec_len(opcode_q)));
            default:  last_s = 1'b0;
        endcase
    end

    // Next-state and opcode capture.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i || step_i) state_d = ST_FETCH;
                else                 state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (phase_s[2]) begin
                    opcode_d = ir_i[7:4];
                    if (last_s) state_d = run_i ? ST_FETCH : ST_IDLE;
                    else        state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (last_s) begin
                    if (opcode_q == OP_HLT) state_d = ST_HALT;
                    else                    state_d = run_i ? ST_FETCH : ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and opcode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Control-word decode.
    always_comb begin
        ctrl_o = '0;
        case (state_q)
            ST_FETCH, ST_EXEC: ctrl_o = ucode(opcode_q, phase_idx_s);
            default:           ctrl_o = '0;
        endcase
    end

    assign phase_o      = phase_s;
    assign busy_o       = busy_s;
    assign instr_done_o = last_s;
    assign halt_o       = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: expected per-cycle outputs are queued as
// stimulus is applied and compared one cycle at a time, 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_cpu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_i;
    logic        step_i;
    logic [7:0]  ir_i;
    logic [7:0]  phase_o;
    logic [15:0] ctrl_o;
    logic        busy_o;
    logic        instr_done_o;
    logic        halt_o;

    logic [26:0] obs_s;
    logic [26:0] exp_r;
    logic [26:0] sb[$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    cpu_ctrl_seq dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .step_i       (step_i),
        .ir_i         (ir_i),
        .phase_o      (phase_o),
        .ctrl_o       (ctrl_o),
        .busy_o       (busy_o),
        .instr_done_o (instr_done_o),
        .halt_o       (halt_o)
    );

    assign obs_s = {halt_o, instr_done_o, busy_o, phase_o, ctrl_o};

    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4:               return 2;
            4'h2, 4'h3:               return 3;
            4'h5, 4'h6, 4'hE, 4'hF:   return 1;
            default:                  return 0;
        endcase
    endfunction

    function automatic logic [15:0] exp_ctrl(input logic [3:0] op, input int t);
        logic [6:0] key;
        if (t == 0) return 16'h0005;
        if (t == 1) return 16'h0028;
        if (t == 2) return 16'h0002;
        key = {op, 3'(t)};
        case (key)
            {4'h1, 3'd3}: return 16'h0044;
            {4'h1, 3'd4}: return 16'h0088;
            {4'h2, 3'd3}: return 16'h0044;
            {4'h2, 3'd4}: return 16'h0208;
            {4'h2, 3'd5}: return 16'h4480;
            {4'h3, 3'd3}: return 16'h0044;
            {4'h3, 3'd4}: return 16'h0208;
            {4'h3, 3'd5}: return 16'h4C80;
            {4'h4, 3'd3}: return 16'h0044;
            {4'h4, 3'd4}: return 16'h0110;
            {4'h5, 3'd3}: return 16'h00C0;
            {4'h6, 3'd3}: return 16'h2040;
            {4'hE, 3'd3}: return 16'h1100;
            {4'hF, 3'd3}: return 16'h8000;
            default:      return 16'h0000;
        endcase
    endfunction

    task automatic push_instr(input logic [3:0] op);
        int last;
        last = 2 + exp_len(op);
        for (int t = 0; t <= last; t++) begin
            sb.push_back({1'b0, (t == last), 1'b1, 8'(1 << t), exp_ctrl(op, t)});
        end
    endtask

    task automatic push_idle(input logic halted);
        sb.push_back({halted, 1'b0, 1'b0, 8'h01, 16'h0000});
    endtask

    task automatic test_reset();
        rst = 1'b0; run_i = 1'b0; step_i = 1'b0; ir_i = 8'h00;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (obs_s !== {1'b0, 1'b0, 1'b0, 8'h01, 16'h0000})
            $display("FAIL reset_state: got %h want %h", obs_s, {1'b0, 1'b0, 1'b0, 8'h01, 16'h0000});
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
        run_i = 1'b1; ir_i = 8'h57;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (phase_o !== 8'h02) $display("FAIL reset_pre_phase: got %h want 02", phase_o);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (phase_o !== 8'h01) $display("FAIL reset_mid_phase: got %h want 01", phase_o);
        else passed++;
        checks++;
        if (ctrl_o !== 16'h0000) $display("FAIL reset_mid_ctrl: got %h want 0000", ctrl_o);
        else passed++;
        checks++;
        if (busy_o !== 1'b0 || instr_done_o !== 1'b0) $display("FAIL reset_mid_busy: got %b%b want 00", busy_o, instr_done_o);
        else passed++;
        run_i = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_free_run_ldi();
        int n;
        run_i = 1'b1; ir_i = 8'h57;
        push_instr(4'h5); push_instr(4'h5); push_idle(1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL free_run_ldi cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            if (i == 4) run_i = 1'b0;
        end
    endtask

    task automatic test_full_add();
        int n;
        run_i = 1'b1; ir_i = 8'h2A;
        push_instr(4'h2); push_idle(1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL full_add cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            if (i == 0) run_i = 1'b0;
        end
    endtask

    task automatic test_single_step();
        int n;
        run_i = 1'b0; ir_i = 8'hE0; step_i = 1'b1;
        push_instr(4'hE); push_idle(1'b0); push_idle(1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL single_step cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            step_i = (i == 1);
        end
        step_i = 1'b0;
    endtask

    task automatic test_stop_mid_sub();
        int n;
        run_i = 1'b1; ir_i = 8'h3C;
        push_instr(4'h3); push_idle(1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL stop_mid_sub cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            if (i == 3) run_i = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3];
        int n;
        ops[0] = 4'h1; ops[1] = 4'h4; ops[2] = 4'h6;
        run_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ir_i = {ops[k], 4'h5};
            push_instr(ops[k]);
            if (k == 2) push_idle(1'b0);
            n = sb.size();
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                exp_r = sb.pop_front();
                checks++;
                if (obs_s !== exp_r) $display("FAIL back_to_back op %h cyc %0d: got %h want %h", ops[k], i, obs_s, exp_r);
                else passed++;
                if (k == 2 && i == 0) run_i = 1'b0;
            end
        end
    endtask

    task automatic test_nop();
        int n;
        run_i = 1'b1; ir_i = 8'h90;
        push_instr(4'h9); push_idle(1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL nop cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            if (i == 0) run_i = 1'b0;
        end
    endtask

    task automatic test_halt();
        int n;
        run_i = 1'b1; ir_i = 8'hF0;
        push_instr(4'hF); push_idle(1'b1); push_idle(1'b1); push_idle(1'b1);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if (obs_s !== exp_r) $display("FAIL halt cyc %0d: got %h want %h", i, obs_s, exp_r);
            else passed++;
            if (i == 4) run_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_s !== {1'b0, 1'b0, 1'b0, 8'h01, 16'h0000})
            $display("FAIL halt_reset: got %h want %h", obs_s, {1'b0, 1'b0, 1'b0, 8'h01, 16'h0000});
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run_ldi();
        test_full_add();
        test_single_step();
        test_stop_mid_sub();
        test_back_to_back();
        test_nop();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
